// File: rtl/ahb_lsram_ctrl_if.sv
// AHB-Lite bus bundle between a master/interconnect and the LSRAM slave.
// Clock and reset stay plain ports on the slave.
interface ahb_lsram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lsram_ctrl.sv
// AHB-Lite slave wrapping an inferred synchronous RAM: byte-lane writes, zero-wait reads with
// write-to-read forwarding, and a two-cycle ERROR response for illegal accesses.
module ahb_lsram_ctrl #(
    parameter int unsigned MEM_DEPTH     = 2048,
    parameter int unsigned APERTURE_BITS = 16
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_lsram_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    // Address bits inside the aperture but above the RAM; any set bit is out of range.
    localparam logic [31:0] ApMask = ((32'd1 << APERTURE_BITS) - 32'd1) &
                                     ~((32'd1 << (AW + 2)) - 32'd1);

    typedef enum logic [1:0] {StOk, StErr1, StErr2} state_e;

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic [1:0]      resp_q, resp_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      lanes_q, lanes_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic [3:0]      fwd_lanes_q, fwd_lanes_d;
    logic [31:0]     fwd_data_q;
    logic [31:0]     ram_rd_q;
    logic [31:0]     mem_q [MEM_DEPTH];

    logic            accept, err, we, rd_acc;
    logic [AW-1:0]   a_idx;
    logic [3:0]      a_lanes;
    logic [31:0]     hrdata;
    logic            unused_bus;

    assign unused_bus = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR};

    assign a_idx  = bus.HADDR[AW+1:2];
    assign accept = bus.HSEL & bus.HREADYIN & bus.HTRANS[1] & ready_q;
    assign rd_acc = accept & ~bus.HWRITE & ~err;
    assign we     = wr_q & bus.HREADYIN & ~HRESET;

    always_comb begin
        a_lanes = 4'b0000;
        err     = |(bus.HADDR & ApMask);
        case (bus.HSIZE)
            3'b000: a_lanes = 4'b0001 << bus.HADDR[1:0];
            3'b001: begin
                a_lanes = bus.HADDR[1] ? 4'b1100 : 4'b0011;
                err     = err | bus.HADDR[0];
            end
            3'b010: begin
                a_lanes = 4'b1111;
                err     = err | (|bus.HADDR[1:0]);
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lanes_d     = lanes_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        fwd_lanes_d = fwd_lanes_q;
        if (accept) begin
            idx_d       = a_idx;
            lanes_d     = a_lanes;
            wr_d        = bus.HWRITE & ~err;
            rd_d        = ~bus.HWRITE & ~err;
            // Write committing on this same edge must show through in the read result.
            fwd_lanes_d = (wr_q && bus.HREADYIN && idx_q == a_idx) ? lanes_q : 4'b0000;
        end else if (bus.HREADYIN) begin
            wr_d = 1'b0;
            rd_d = 1'b0;
        end
        case (state_q)
            StOk:    if (accept && err) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = (accept && err) ? StErr1 : StOk;
            default: state_d = StOk;
        endcase
        ready_d = (state_d != StErr1);
        resp_d  = (state_d == StOk) ? 2'b00 : 2'b01;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StOk;
            ready_q     <= 1'b1;
            resp_q      <= 2'b00;
            idx_q       <= '0;
            lanes_q     <= 4'b0000;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            fwd_lanes_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            resp_q      <= resp_d;
            idx_q       <= idx_d;
            lanes_q     <= lanes_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fwd_lanes_q <= fwd_lanes_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) fwd_data_q <= bus.HWDATA;
    end

    // Read-first RAM; contents deliberately survive reset.
    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                if (lanes_q[l]) mem_q[idx_q][8*l +: 8] <= bus.HWDATA[8*l +: 8];
            end
        end
        if (rd_acc) ram_rd_q <= mem_q[a_idx];
    end

    always_comb begin
        hrdata = '0;
        if (rd_q) begin
            for (int l = 0; l < 4; l++) begin
                hrdata[8*l +: 8] = fwd_lanes_q[l] ? fwd_data_q[8*l +: 8] : ram_rd_q[8*l +: 8];
            end
        end
    end

    assign bus.HRDATA    = hrdata;
    assign bus.HREADYOUT = ready_q;
    assign bus.HRESP     = resp_q;
endmodule

// File: tb/tb_ahb_lsram_ctrl.sv
// Scoreboard bench for ahb_lsram_ctrl: a byte-addressed memory model predicts every response,
// and an independent bus monitor checks each data phase as it completes.
module tb_ahb_lsram_ctrl;
    localparam int unsigned Depth = 2048;
    localparam logic [1:0]  Nonseq = 2'b10;
    localparam logic [1:0]  Seq = 2'b11;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    bit   stall = 1'b0;
    bit   last_err = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] model_mem [Depth];
    exp_t        sb [$];

    ahb_lsram_ctrl_if bus ();

    ahb_lsram_ctrl #(
        .MEM_DEPTH    (Depth),
        .APERTURE_BITS(16)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    // The LSRAM is the only slave, so bus ready follows it except for injected stalls.
    assign bus.HREADYIN = bus.HREADYOUT & ~stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        return ((a % 65536) >= Depth * 4) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
               (sz == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [2:0] sz,
                                        input logic [31:0] wd);
        int idx;
        int lane;
        idx = int'((a >> 2) % Depth);
        for (int b = 0; b < (1 << sz); b++) begin
            lane = int'(a % 4) + b;
            model_mem[idx][8*lane +: 8] = wd[8*lane +: 8];
        end
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge HCLK);
        while (!bus.HREADYIN && n < 20) begin
            @(negedge HCLK);
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL %s: HREADYIN low for %0d cycles, limit 20", name, n);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [1:0] tr, input logic [2:0] burst,
                        input bit stl, input bit commit);
        exp_t e;
        bus.HSEL   = 1'b1;
        bus.HADDR  = a;
        bus.HWRITE = w;
        bus.HSIZE  = sz;
        bus.HTRANS = tr;
        bus.HBURST = burst;
        if (stl) begin
            stall = 1'b1;
            @(posedge HCLK);
            #1;
            stall = 1'b0;
        end
        wait_ready("addr_accept");
        @(posedge HCLK);
        #1;
        e.err   = is_err(a, sz);
        e.rdata = 32'h0;
        if (commit) begin
            if (!e.err) begin
                if (w) model_write(a, sz, wd);
                else e.rdata = model_mem[int'((a >> 2) % Depth)];
            end
            sb.push_back(e);
        end
        last_err   = e.err;
        bus.HWDATA = w ? wd : $urandom;
    endtask

    task automatic idle();
        bus.HSEL   = 1'($urandom_range(0, 1));
        bus.HTRANS = 2'($urandom_range(0, 1));
        bus.HADDR  = $urandom;
        bus.HWRITE = 1'($urandom_range(0, 1));
        wait_ready("idle_wait");
        @(posedge HCLK);
        #1;
        bus.HWDATA = $urandom;
        last_err   = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        stall  = 1'b0;
        repeat (2) begin
            bus.HSEL   = 1'($urandom_range(0, 1));
            bus.HADDR  = 32'($urandom_range(0, 255));
            bus.HTRANS = 2'($urandom_range(0, 3));
            bus.HWRITE = 1'($urandom_range(0, 1));
            bus.HSIZE  = 3'($urandom_range(0, 7));
            bus.HWDATA = $urandom;
            @(posedge HCLK);
            #1;
            chk("reset_hreadyout", 32'(bus.HREADYOUT), 32'h1);
            chk("reset_hresp", 32'(bus.HRESP), 32'h0);
            chk("reset_hrdata", bus.HRDATA, 32'h0);
        end
        HRESET     = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        last_err   = 1'b0;
    endtask

    // Monitor: follows data phases from bus activity alone and pops one expectation per phase.
    bit   in_dp = 1'b0;
    int   low_cycles = 0;
    exp_t mon_e;
    always @(negedge HCLK) begin
        if (HRESET) begin
            in_dp      = 1'b0;
            low_cycles = 0;
        end else begin
            if (in_dp) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'h1);
                end else if (!bus.HREADYOUT) begin
                    low_cycles++;
                    chk("err1_hresp", 32'(bus.HRESP), 32'h1);
                end else if (!bus.HREADYIN) begin
                    chk("stall_hresp", 32'(bus.HRESP), 32'h0);
                    chk("stall_hrdata", bus.HRDATA, sb[0].rdata);
                end else begin
                    mon_e = sb.pop_front();
                    chk("dphase_hresp", 32'(bus.HRESP), mon_e.err ? 32'h1 : 32'h0);
                    chk("dphase_hrdata", bus.HRDATA, mon_e.rdata);
                    chk("dphase_wait_states", 32'(low_cycles), mon_e.err ? 32'h1 : 32'h0);
                    low_cycles = 0;
                end
            end else begin
                chk("idle_hreadyout", 32'(bus.HREADYOUT), 32'h1);
                chk("idle_hresp", 32'(bus.HRESP), 32'h0);
                chk("idle_hrdata", bus.HRDATA, 32'h0);
            end
            if (bus.HSEL && bus.HREADYIN && bus.HTRANS[1] && bus.HREADYOUT) in_dp = 1'b1;
            else if (bus.HREADYIN) in_dp = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int          kind;
        int          n;
        logic [31:0] a;
        logic [2:0]  sz;
        bit          stl;

        bus.HSEL   = 1'b0;
        bus.HADDR  = 32'h0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b000;
        bus.HBURST = 3'b000;
        bus.HWDATA = 32'h0;
        do_reset();

        // Preload the low 64 words so every later read has a known value.
        for (int i = 0; i < 64; i++) xfer(32'(i * 4), 1'b1, 3'd2, $urandom,
                                          (i == 0) ? Nonseq : Seq, 3'b001, 1'b0, 1'b1);
        idle();

        // Write whose data phase ends on a reset edge must be dropped.
        xfer(32'h40, 1'b1, 3'd2, 32'hFFFF_0000, Nonseq, 3'b000, 1'b0, 1'b0);
        do_reset();
        xfer(32'h40, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        idle();

        // Forwarding from an in-flight write.
        xfer(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h10, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        idle();

        // Byte and halfword lanes; unused HWDATA bytes carry junk.
        xfer(32'h10, 1'b1, 3'd2, 32'h1122_3344, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h13, 1'b1, 3'd0, 32'hAA5A_5A5A, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h10, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h10, 1'b1, 3'd1, 32'h9999_5566, Nonseq, 3'b000, 1'b0, 1'b1);
        idle();
        xfer(32'h10, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        idle();

        // Out of range, then a good read.
        xfer(32'h2000, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h0, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        idle();

        // Misaligned word and oversize writes must not touch the RAM.
        xfer(32'h06, 1'b1, 3'd2, 32'hFFFF_FFFF, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h04, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h08, 1'b1, 3'd3, 32'hFFFF_FFFF, Nonseq, 3'b000, 1'b0, 1'b1);
        xfer(32'h08, 1'b0, 3'd2, 32'h0, Nonseq, 3'b000, 1'b0, 1'b1);
        idle();

        // INCR4 write with beat 2 stalled, then INCR4 read.
        for (int i = 0; i < 4; i++) xfer(32'h20 + 32'(i * 4), 1'b1, 3'd2, 32'(i + 1),
                                         (i == 0) ? Nonseq : Seq, 3'b011, (i == 2), 1'b1);
        for (int i = 0; i < 4; i++) xfer(32'h20 + 32'(i * 4), 1'b0, 3'd2, 32'h0,
                                         (i == 0) ? Nonseq : Seq, 3'b011, 1'b0, 1'b1);
        idle();

        // Random mix inside the preloaded window, plus illegal and aliased addresses.
        for (int t = 0; t < 400; t++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                idle();
            end else begin
                a  = 32'($urandom_range(0, 255));
                if (kind == 1) a = 32'($urandom_range(32'h2000, 32'hFFFF));
                if (kind == 2) a = a | (32'($urandom_range(1, 255)) << 16);
                sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7))
                                                  : 3'($urandom_range(0, 2));
                if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                stl = !last_err && ($urandom_range(0, 7) == 0);
                xfer(a, 1'($urandom_range(0, 1)), sz, $urandom, 2'($urandom_range(2, 3)),
                     3'b001, stl, 1'b1);
            end
        end
        idle();

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge HCLK);
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
